// File: rtl/tl_lamp_monitor.sv
// Light-code receiver: decodes A/B codes to one-hot lamps and traps protocol violations into flashing-red FAULT.
// Build option TL_MON_DWELL_CHECK_EN adds yellow-dwell counters and the short-yellow fault (code 5).
module tl_lamp_monitor #(
  parameter int YEL_MIN   = 3,
  parameter int FLASH_DIV = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] La,
  input  logic [1:0] Lb,
  input  logic       fault_clr,
  output logic [2:0] lamp_a,
  output logic [2:0] lamp_b,
  output logic       fault,
  output logic [2:0] fault_code
);
  localparam logic [1:0] C_G = 2'b00;
  localparam logic [1:0] C_Y = 2'b01;
  localparam logic [1:0] C_R = 2'b10;
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);

  if (YEL_MIN < 1 || FLASH_DIV < 1) begin : g_param_check
    $error("tl_lamp_monitor: YEL_MIN and FLASH_DIV must both be >= 1");
  end

  typedef enum logic [1:0] {SYNC, RUN, FAULT} state_t;

  state_t        state, state_nxt;
  logic [1:0]    la_q, lb_q, la_p, lb_p;
  logic [FW-1:0] flash_cnt, flash_cnt_nxt;
  logic          flash_off, flash_off_nxt;
  logic [2:0]    lamp_a_nxt, lamp_b_nxt, code_nxt, cause;
  logic          short_y;

  function automatic logic [2:0] decode(input logic [1:0] c);
    case (c)
      C_G:     decode = 3'b001;
      C_Y:     decode = 3'b010;
      default: decode = 3'b100;
    endcase
  endfunction

  function automatic logic legal_tr(input logic [1:0] p, input logic [1:0] q);
    case ({p, q})
      {C_G, C_G}, {C_G, C_Y}, {C_Y, C_Y},
      {C_Y, C_R}, {C_R, C_R}, {C_R, C_G}: legal_tr = 1'b1;
      default:                            legal_tr = 1'b0;
    endcase
  endfunction

`ifdef TL_MON_DWELL_CHECK_EN
  localparam int DW = $clog2(YEL_MIN + 1);
  localparam logic [DW-1:0] DW_MAX = DW'(YEL_MIN);

  logic [DW-1:0] dwell_a, dwell_b;

  // Counter trails la_q by one cycle, so on Y->R it still holds the yellow length just shown.
  function automatic logic [DW-1:0] dwell_step(input logic [1:0] q, input logic [1:0] p,
                                               input logic [DW-1:0] cnt);
    if (q != C_Y)          dwell_step = '0;
    else if (p != C_Y)     dwell_step = DW'(1);
    else if (cnt == DW_MAX) dwell_step = cnt;
    else                   dwell_step = cnt + DW'(1);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dwell_a <= '0;
      dwell_b <= '0;
    end else if (state == FAULT && fault_clr) begin
      dwell_a <= '0;
      dwell_b <= '0;
    end else begin
      dwell_a <= dwell_step(la_q, la_p, dwell_a);
      dwell_b <= dwell_step(lb_q, lb_p, dwell_b);
    end
  end

  assign short_y = (la_p == C_Y && la_q == C_R && dwell_a < DW_MAX) ||
                   (lb_p == C_Y && lb_q == C_R && dwell_b < DW_MAX);
`else
  assign short_y = 1'b0;
`endif

  always_comb begin
    cause = 3'd0;
    if (la_q != C_R && lb_q != C_R)                 cause = 3'd1;
    else if (la_q == 2'b11 || lb_q == 2'b11)        cause = 3'd2;
    else if (state == RUN && !legal_tr(la_p, la_q)) cause = 3'd3;
    else if (state == RUN && !legal_tr(lb_p, lb_q)) cause = 3'd4;
    else if (state == RUN && short_y)               cause = 3'd5;
  end

  always_comb begin
    state_nxt     = state;
    flash_cnt_nxt = flash_cnt;
    flash_off_nxt = flash_off;
    lamp_a_nxt    = lamp_a;
    lamp_b_nxt    = lamp_b;
    code_nxt      = fault_code;
    case (state)
      SYNC, RUN: begin
        if (cause != 3'd0) begin
          state_nxt     = FAULT;
          code_nxt      = cause;
          flash_cnt_nxt = '0;
          flash_off_nxt = 1'b0;
          lamp_a_nxt    = LAMP_RED;
          lamp_b_nxt    = LAMP_RED;
        end else begin
          state_nxt  = RUN;
          lamp_a_nxt = decode(la_q);
          lamp_b_nxt = decode(lb_q);
        end
      end
      FAULT: begin
        if (fault_clr) begin
          state_nxt  = SYNC;
          code_nxt   = 3'd0;
          lamp_a_nxt = LAMP_RED;
          lamp_b_nxt = LAMP_RED;
        end else if (flash_cnt == FLASH_LAST) begin
          flash_cnt_nxt = '0;
          flash_off_nxt = ~flash_off;
          lamp_a_nxt    = flash_off ? LAMP_RED : 3'b000;
          lamp_b_nxt    = flash_off ? LAMP_RED : 3'b000;
        end else begin
          flash_cnt_nxt = flash_cnt + FW'(1);
        end
      end
      default: state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      la_q       <= C_R;
      lb_q       <= C_R;
      la_p       <= C_R;
      lb_p       <= C_R;
      state      <= SYNC;
      flash_cnt  <= '0;
      flash_off  <= 1'b0;
      lamp_a     <= LAMP_RED;
      lamp_b     <= LAMP_RED;
      fault_code <= 3'd0;
    end else begin
      la_q       <= La;
      lb_q       <= Lb;
      la_p       <= la_q;
      lb_p       <= lb_q;
      state      <= state_nxt;
      flash_cnt  <= flash_cnt_nxt;
      flash_off  <= flash_off_nxt;
      lamp_a     <= lamp_a_nxt;
      lamp_b     <= lamp_b_nxt;
      fault_code <= code_nxt;
    end
  end

  assign fault = (state == FAULT);

endmodule

// File: doc/tl_lamp_monitor.md
# tl_lamp_monitor

Receiving end of the traffic-light controller's light-code interface. Samples the 2-bit light codes for directions A and B, decodes them into one-hot lamp drives, and independently checks the stream for conflicting greens, illegal codes, illegal colour sequences and short yellows. On any violation it latches a fault and forces both directions to flashing red until software clears it.

## Interface
- YEL_MIN, default 3: minimum consecutive cycles a direction must show YELLOW before RED; legal range ≥1.
- FLASH_DIV, default 8: cycles per flash half-period in fault mode; legal range ≥1.
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- La  in  2  direction A code: 00 GREEN, 01 YELLOW, 10 RED, 11 illegal.
- Lb  in  2  direction B code, same encoding.
- fault_clr  in  1  single-cycle request to leave fault mode; ignored outside FAULT.
- lamp_a  out  3  {red,yellow,green} one-hot drive for A.
- lamp_b  out  3  {red,yellow,green} one-hot drive for B.
- fault  out  1  high while in FAULT.
- fault_code  out  3  first-detected cause, held until cleared.

## Operation
- Input stage: la_q/lb_q register La/Lb every cycle; la_p/lb_p register la_q/lb_q (previous sample).
- States: SYNC, RUN, FAULT. Reset enters SYNC.
- SYNC: one cycle; decode outputs, check conflict and illegal code only (no transition check, la_p invalid); then RUN.
- RUN: all checks active; outputs = decode(la_q), decode(lb_q).
- Legal per-direction transitions (la_p→la_q): G→G, G→Y, Y→Y, Y→R, R→R, R→G. Anything else is illegal.
- Checks and fault_code, priority high to low when simultaneous: 1 conflict (both la_q and lb_q non-RED, any codes); 2 illegal code 11 on either; 3 illegal transition A; 4 illegal transition B; 5 short yellow (either direction).
- Yellow dwell counter per direction: la_q=Y and la_p≠Y → 1; la_q=Y and la_p=Y → +1 saturating at YEL_MIN; otherwise 0. On Y→R, counter value < YEL_MIN → short yellow.
- Any check firing in SYNC or RUN → FAULT next edge; fault_code latched once, not overwritten by later violations.
- FAULT: lamp_a=lamp_b alternate 100 / 000, each phase FLASH_DIV cycles, starting with 100 on entry; flash counter wraps at FLASH_DIV-1. Inputs keep being sampled but are not checked.
- fault_clr=1 in FAULT → SYNC next edge; fault→0, fault_code→0, dwell counters→0. Faults detected in the following SYNC cycle re-enter FAULT.

## Timing
- Reset values: lamp_a=lamp_b=3'b100, fault=0, fault_code=0, la_q/lb_q/la_p/lb_p=RED, counters 0, state SYNC.
- Latency: code applied before edge k lands in la_q at k; lamp outputs reflect it after edge k+1.
- Violation present in la_q after edge k → fault=1, code valid, lamps=100 after edge k+1.
- fault_clr sampled high at edge k → fault=0 after edge k; lamps decode la_q after edge k+1.
- Reset asserted mid-fault or mid-flash: immediate return to reset values; no retained fault.

## Configuration
- TL_MON_DWELL_CHECK_EN defined: yellow dwell counters and fault_code 5 present as above.
- Undefined: counters removed, Y→R always legal, code 5 never produced; YEL_MIN unused.

## Test plan
- Reset, then A: G×5, Y×3, R; B: R×9, then G -> lamps follow codes 2 cycles late, fault stays 0 throughout.
- La=00, Lb=01 simultaneously -> fault=1, fault_code=1, lamps 100 two cycles after application.
- A goes G→R directly with B=R -> fault_code=3; repeat for B R→Y -> fault_code=4.
- With macro, A yellow 2 cycles then R (YEL_MIN=3) -> fault_code=5; without macro -> no fault.
- In FAULT with FLASH_DIV=8: lamps 100 for 8 cycles, 000 for 8, repeat; pulse fault_clr with legal inputs -> fault=0, code=0, normal decode resumes.
- Drive La=11 while simultaneously pulsing reset_n low mid-flash -> all outputs at reset values; after release, La=11 -> fault_code=2 from SYNC.
